// File: rtl/ccc_clk_manager.sv
// Fabric clock/reset manager: lock qualification, staggered per-domain reset
// release, per-domain programmable clock enables and lock-loss tracking.

module ccc_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic             load,
  input  logic [DIV_W-1:0] val,
  output logic             ce
);
  logic [DIV_W-1:0] r;
  logic [DIV_W-1:0] c;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r  <= DIV_W'(1);
      c  <= '0;
      ce <= 1'b0;
    end else if (load) begin
      r  <= val;
      c  <= '0;
      ce <= 1'b0;
    end else if (!run) begin
      c  <= '0;
      ce <= 1'b0;
    end else if (r <= DIV_W'(1) || c == r - DIV_W'(1)) begin
      c  <= '0;
      ce <= 1'b1;
    end else begin
      c  <= c + DIV_W'(1);
      ce <= 1'b0;
    end
  end
endmodule

module ccc_clk_manager #(
  parameter int NUM_CH             = 4,
  parameter int DIV_W              = 8,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_STAGGER        = 16,
  parameter int CNT_W              = 8
) (
  input  logic                    FAB_CLK,
  input  logic                    M2F_RESET_N,
  input  logic                    FAB_LOCK,
  input  logic                    MSS_LOCK,
  input  logic [NUM_CH*DIV_W-1:0] DIV_VAL,
  input  logic [NUM_CH-1:0]       DIV_LOAD,
  input  logic                    CLR_LOST,
  output logic [NUM_CH-1:0]       CH_RST_N,
  output logic [NUM_CH-1:0]       CE,
  output logic                    READY,
  output logic                    LOCK_LOST,
  output logic [CNT_W-1:0]        LOSS_CNT
);
  localparam int SW = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int GW = $clog2(RST_STAGGER + 1);
  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [SW-1:0] STAB_LAST = SW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(RST_STAGGER - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_CH - 1);

  typedef enum logic [2:0] {WAIT, STABLE, RELEASE, RUN, LOST} state_t;

  state_t                          state;
  logic [1:0]                      fab_sync, mss_sync;
  logic                            lock_ok;
  logic [SW-1:0]                   stab_cnt;
  logic [GW-1:0]                   gap_cnt;
  logic [IW-1:0]                   idx;
  logic [NUM_CH-1:0]               ch_rst_n;
  logic                            ready;
  logic                            lock_lost;
  logic [CNT_W-1:0]                loss_cnt;
  logic                            drop;
  logic [NUM_CH-1:0]               ch_run;
  logic [NUM_CH-1:0][DIV_W-1:0]    div_val;
  logic [NUM_CH-1:0]               ce;

  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      fab_sync <= '0;
      mss_sync <= '0;
    end else begin
      fab_sync <= {fab_sync[0], FAB_LOCK};
      mss_sync <= {mss_sync[0], MSS_LOCK};
    end
  end

  assign lock_ok = fab_sync[1] & mss_sync[1];

  always_ff @(posedge FAB_CLK) begin
    if (!M2F_RESET_N) begin
      state     <= WAIT;
      stab_cnt  <= '0;
      gap_cnt   <= '0;
      idx       <= '0;
      ch_rst_n  <= '0;
      ready     <= 1'b0;
      lock_lost <= 1'b0;
      loss_cnt  <= '0;
    end else begin
      // a lock-loss set later in this block overrides the clear
      if (CLR_LOST) lock_lost <= 1'b0;
      case (state)
        WAIT: begin
          ch_rst_n <= '0;
          ready    <= 1'b0;
          if (lock_ok) begin
            state    <= STABLE;
            stab_cnt <= '0;
          end
        end
        STABLE: begin
          if (!lock_ok) state <= WAIT;
          else if (stab_cnt == STAB_LAST) begin
            state   <= RELEASE;
            idx     <= '0;
            gap_cnt <= '0;
          end else stab_cnt <= stab_cnt + SW'(1);
        end
        RELEASE: begin
          if (!lock_ok) begin
            state     <= LOST;
            ch_rst_n  <= '0;
            ready     <= 1'b0;
            lock_lost <= 1'b1;
            if (loss_cnt != '1) loss_cnt <= loss_cnt + CNT_W'(1);
          end else if (gap_cnt != '0) gap_cnt <= gap_cnt - GW'(1);
          else begin
            ch_rst_n[idx] <= 1'b1;
            gap_cnt       <= GAP_LAST;
            if (idx == IDX_LAST) begin
              state <= RUN;
              ready <= 1'b1;
            end else idx <= idx + IW'(1);
          end
        end
        RUN: begin
          if (!lock_ok) begin
            state     <= LOST;
            ch_rst_n  <= '0;
            ready     <= 1'b0;
            lock_lost <= 1'b1;
            if (loss_cnt != '1) loss_cnt <= loss_cnt + CNT_W'(1);
          end
        end
        LOST: begin
          ch_rst_n <= '0;
          ready    <= 1'b0;
          state    <= WAIT;
        end
        default: state <= WAIT;
      endcase
    end
  end

  // dividers see the reset that is about to be applied so CE never outlives a lock loss
  assign drop    = ~lock_ok & ((state == RELEASE) | (state == RUN));
  assign ch_run  = ch_rst_n & {NUM_CH{~drop}};
  assign div_val = DIV_VAL;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_div
    ccc_clk_div #(.DIV_W(DIV_W)) u_div (
      .clk  (FAB_CLK),
      .rst_n(M2F_RESET_N),
      .run  (ch_run[i]),
      .load (DIV_LOAD[i]),
      .val  (div_val[i]),
      .ce   (ce[i])
    );
  end

  assign CH_RST_N  = ch_rst_n;
  assign CE        = ce;
  assign READY     = ready;
  assign LOCK_LOST = lock_lost;
  assign LOSS_CNT  = loss_cnt;
endmodule

// File: tb/tb_ccc_clk_manager.sv
// Scenario bench for ccc_clk_manager: expected release/CE events are queued at
// stimulus time and matched against observed edges.

module tb_ccc_clk_manager;
  localparam int NCH = 4;
  localparam int DW  = 8;
  localparam int LSC = 8;
  localparam int STG = 4;
  localparam int CW  = 8;

  logic                FAB_CLK = 1'b0;
  logic                M2F_RESET_N;
  logic                FAB_LOCK, MSS_LOCK;
  logic [NCH*DW-1:0]   DIV_VAL;
  logic [NCH-1:0]      DIV_LOAD;
  logic                CLR_LOST;
  logic [NCH-1:0]      CH_RST_N;
  logic [NCH-1:0]      CE;
  logic                READY;
  logic                LOCK_LOST;
  logic [CW-1:0]       LOSS_CNT;

  ccc_clk_manager #(
    .NUM_CH(NCH), .DIV_W(DW), .LOCK_STABLE_CYCLES(LSC), .RST_STAGGER(STG), .CNT_W(CW)
  ) dut (
    .FAB_CLK(FAB_CLK), .M2F_RESET_N(M2F_RESET_N), .FAB_LOCK(FAB_LOCK), .MSS_LOCK(MSS_LOCK),
    .DIV_VAL(DIV_VAL), .DIV_LOAD(DIV_LOAD), .CLR_LOST(CLR_LOST), .CH_RST_N(CH_RST_N),
    .CE(CE), .READY(READY), .LOCK_LOST(LOCK_LOST), .LOSS_CNT(LOSS_CNT)
  );

  always #5 FAB_CLK = ~FAB_CLK;

  typedef struct { int ch; int at; } rise_t;

  int    cyc = 0;
  int    n_chk = 0;
  int    n_fail = 0;
  rise_t rise_q[$];
  int    ready_q[$];
  int    ce_q[$];

  task automatic step(input int n);
    repeat (n) begin
      @(posedge FAB_CLK);
      #1;
      cyc++;
    end
  endtask

  // locks become good at the current cycle: 2 sync + 1 WAIT + LSC stable + 1 release
  task automatic bring_up(input int nch);
    for (int i = 0; i < nch; i++) rise_q.push_back('{i, cyc + LSC + 4 + i * STG});
    if (nch == NCH) ready_q.push_back(cyc + LSC + 4 + (NCH - 1) * STG);
  endtask

  task automatic watch(input int n);
    logic [NCH-1:0] prev;
    logic           prev_rdy;
    rise_t          e;
    int             er;
    prev     = CH_RST_N;
    prev_rdy = READY;
    repeat (n) begin
      step(1);
      for (int i = 0; i < NCH; i++) begin
        if (CH_RST_N[i] && !prev[i]) begin
          n_chk++;
          if (rise_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rise ch%0d at cycle %0d", i, cyc);
          end else begin
            e = rise_q.pop_front();
            if (e.ch !== i || e.at !== cyc) begin
              n_fail++;
              $display("FAIL rise_order got ch%0d@%0d expected ch%0d@%0d", i, cyc, e.ch, e.at);
            end
          end
        end
      end
      if (READY && !prev_rdy) begin
        n_chk++;
        if (ready_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_ready at cycle %0d", cyc);
        end else begin
          er = ready_q.pop_front();
          if (er !== cyc) begin
            n_fail++;
            $display("FAIL ready_time got %0d expected %0d", cyc, er);
          end
        end
      end
      prev     = CH_RST_N;
      prev_rdy = READY;
    end
    n_chk++;
    if (rise_q.size() != 0 || ready_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events rises_left=%0d ready_left=%0d", rise_q.size(), ready_q.size());
      rise_q.delete();
      ready_q.delete();
    end
  endtask

  task automatic apply_reset();
    M2F_RESET_N = 1'b0;
    FAB_LOCK    = 1'b0;
    MSS_LOCK    = 1'b0;
    DIV_VAL     = '0;
    DIV_LOAD    = '0;
    CLR_LOST    = 1'b0;
    step(2);
    M2F_RESET_N = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_chk++;
    if (CH_RST_N !== '0 || CE !== '0 || READY !== 1'b0 || LOCK_LOST !== 1'b0 || LOSS_CNT !== '0) begin
      n_fail++;
      $display("FAIL reset_state got rst=%b ce=%b rdy=%b lost=%b cnt=%0d expected all zero",
               CH_RST_N, CE, READY, LOCK_LOST, LOSS_CNT);
    end
  endtask

  task automatic test_release();
    apply_reset();
    FAB_LOCK = 1'b1;
    MSS_LOCK = 1'b1;
    bring_up(NCH);
    watch(LSC + 4 + NCH * STG + 4);
    n_chk++;
    if (CH_RST_N !== 4'hF || READY !== 1'b1 || LOCK_LOST !== 1'b0) begin
      n_fail++;
      $display("FAIL release_final got rst=%b rdy=%b lost=%b expected 1111 1 0", CH_RST_N, READY, LOCK_LOST);
    end
  endtask

  task automatic test_glitch();
    apply_reset();
    FAB_LOCK = 1'b1;
    MSS_LOCK = 1'b1;
    watch(6);
    FAB_LOCK = 1'b0;
    watch(3);
    FAB_LOCK = 1'b1;
    bring_up(NCH);
    watch(40);
    n_chk++;
    if (LOCK_LOST !== 1'b0 || LOSS_CNT !== '0) begin
      n_fail++;
      $display("FAIL glitch_no_loss got lost=%b cnt=%0d expected 0 0", LOCK_LOST, LOSS_CNT);
    end
  endtask

  task automatic test_loss();
    MSS_LOCK = 1'b0;
    step(2);
    n_chk++;
    if (CH_RST_N !== 4'hF || READY !== 1'b1) begin
      n_fail++;
      $display("FAIL loss_early got rst=%b rdy=%b expected 1111 1", CH_RST_N, READY);
    end
    step(1);
    n_chk++;
    if (CH_RST_N !== '0 || READY !== 1'b0 || LOCK_LOST !== 1'b1 || LOSS_CNT !== 8'd1 || CE !== '0) begin
      n_fail++;
      $display("FAIL loss_state got rst=%b rdy=%b lost=%b cnt=%0d ce=%b expected 0000 0 1 1 0000",
               CH_RST_N, READY, LOCK_LOST, LOSS_CNT, CE);
    end
    MSS_LOCK = 1'b1;
    bring_up(NCH);
    watch(30);
  endtask

  task automatic test_div();
    int ld;
    int exp_ce;
    DIV_VAL = {8'd1, 8'd1, 8'd5, 8'd0};
    DIV_LOAD = 4'b0011;
    ld = cyc + 1;
    for (int k = 1; k <= 4; k++) ce_q.push_back(ld + 5 * k);
    step(1);
    DIV_LOAD = '0;
    n_chk++;
    if (CE[1:0] !== 2'b00) begin
      n_fail++;
      $display("FAIL div_load_suppress got ce=%b expected 00", CE[1:0]);
    end
    for (int k = 1; k <= 21; k++) begin
      step(1);
      n_chk++;
      if (CE[0] !== 1'b1) begin
        n_fail++;
        $display("FAIL div_ratio0 at cycle %0d got %b expected 1", cyc, CE[0]);
      end
      if (CE[1]) begin
        n_chk++;
        if (ce_q.size() == 0) begin
          n_fail++;
          $display("FAIL div_extra_ce1 at cycle %0d", cyc);
        end else begin
          exp_ce = ce_q.pop_front();
          if (exp_ce !== cyc) begin
            n_fail++;
            $display("FAIL div_ce1_time got %0d expected %0d", cyc, exp_ce);
          end
        end
      end
    end
    n_chk++;
    if (ce_q.size() != 0) begin
      n_fail++;
      $display("FAIL div_missing_ce1 left=%0d", ce_q.size());
      ce_q.delete();
    end
  endtask

  task automatic test_reset_midop();
    M2F_RESET_N = 1'b0;
    step(1);
    n_chk++;
    if (CH_RST_N !== '0 || CE !== '0 || READY !== 1'b0 || LOCK_LOST !== 1'b0 || LOSS_CNT !== '0) begin
      n_fail++;
      $display("FAIL midop_reset got rst=%b ce=%b rdy=%b lost=%b cnt=%0d expected all zero",
               CH_RST_N, CE, READY, LOCK_LOST, LOSS_CNT);
    end
    M2F_RESET_N = 1'b1;
    bring_up(NCH);
    watch(30);
    step(1);
    n_chk++;
    if (CE !== 4'hF) begin
      n_fail++;
      $display("FAIL midop_ratio_revert got ce=%b expected 1111", CE);
    end
  endtask

  task automatic test_mid_release();
    apply_reset();
    FAB_LOCK = 1'b1;
    MSS_LOCK = 1'b1;
    bring_up(2);
    watch(LSC + 4 + STG);
    FAB_LOCK = 1'b0;
    step(2);
    n_chk++;
    if (CH_RST_N !== 4'b0011) begin
      n_fail++;
      $display("FAIL midrel_partial got rst=%b expected 0011", CH_RST_N);
    end
    CLR_LOST = 1'b1;
    step(1);
    CLR_LOST = 1'b0;
    n_chk++;
    if (CH_RST_N !== '0 || CE !== '0 || LOCK_LOST !== 1'b1 || LOSS_CNT !== 8'd1) begin
      n_fail++;
      $display("FAIL midrel_loss got rst=%b ce=%b lost=%b cnt=%0d expected 0000 0000 1 1",
               CH_RST_N, CE, LOCK_LOST, LOSS_CNT);
    end
    FAB_LOCK = 1'b1;
    bring_up(NCH);
    step(1);
    n_chk++;
    if (LOCK_LOST !== 1'b1) begin
      n_fail++;
      $display("FAIL lost_sticky got %b expected 1", LOCK_LOST);
    end
    CLR_LOST = 1'b1;
    step(1);
    CLR_LOST = 1'b0;
    n_chk++;
    if (LOCK_LOST !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_lost got %b expected 0", LOCK_LOST);
    end
    watch(32);
  endtask

  task automatic test_saturate();
    int expc;
    apply_reset();
    for (int k = 1; k <= 260; k++) begin
      FAB_LOCK = 1'b1;
      MSS_LOCK = 1'b1;
      step(LSC + 5);
      FAB_LOCK = 1'b0;
      step(4);
      if (k == 1 || k == 254 || k == 255 || k == 256 || k == 260) begin
        expc = (k > 255) ? 255 : k;
        n_chk++;
        if (LOSS_CNT !== 8'(expc) || LOCK_LOST !== 1'b1) begin
          n_fail++;
          $display("FAIL loss_cnt event %0d got cnt=%0d lost=%b expected %0d 1", k, LOSS_CNT, LOCK_LOST, expc);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_release();
    test_glitch();
    test_loss();
    test_div();
    test_reset_midop();
    test_mid_release();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
